ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv.sv | 166 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative integer multiply/divide unit: radix-2 shift-add multiply and restoring
// shift-subtract divide over XLEN cycles, with registered result and writeback.
module ex_muldiv #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    input  logic [REG_AW-1:0] w_addr_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [XLEN-1:0]   result_o,
    output logic              w_enable_o,
    output logic [REG_AW-1:0] w_addr_o
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state_q, state_d;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   hi_q, lo_q, opb_q;
    logic              neg_a_q, neg_b_q;
    logic [REG_AW-1:0] addr_q;
    logic [CW-1:0]     cnt_q;

    // Request decode
    logic            is_div, a_signed, b_signed, a_neg, b_neg, div_zero, ovf, fast, accept;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;

    always_comb begin
        is_div   = op_i[2];
        a_signed = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
        b_signed = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
        a_neg    = a_signed & a_i[XLEN-1];
        b_neg    = b_signed & b_i[XLEN-1];
        a_mag    = a_neg ? -a_i : a_i;
        b_mag    = b_neg ? -b_i : b_i;
        div_zero = is_div && (b_i == '0);
        ovf      = is_div && !op_i[0] && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
        fast     = div_zero || ovf;
        if (div_zero) fast_res = op_i[1] ? a_i : '1;
        else          fast_res = op_i[1] ? '0 : a_i;
        accept   = ((state_q == IDLE) || (state_q == DONE)) && start_i && !flush_i;
    end

    // One iteration step for each algorithm
    logic [XLEN:0]   sum, rs, diff;
    logic [XLEN-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;
    logic            ge;

    always_comb begin
        sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        mul_hi_n = sum[XLEN:1];
        mul_lo_n = {sum[0], lo_q[XLEN-1:1]};
        rs       = {hi_q, lo_q[XLEN-1]};
        diff     = rs - {1'b0, opb_q};
        ge       = !diff[XLEN];
        div_hi_n = ge ? diff[XLEN-1:0] : rs[XLEN-1:0];
        div_lo_n = {lo_q[XLEN-2:0], ge};
    end

    // Sign correction and result selection
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quot, rem, fix_res;

    always_comb begin
        prod   = {hi_q, lo_q};
        prod_s = (neg_a_q ^ neg_b_q) ? -prod : prod;
        quot   = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
        rem    = neg_a_q ? -hi_q : hi_q;
        if (op_q[2])              fix_res = op_q[1] ? rem : quot;
        else if (op_q == 3'd0)    fix_res = prod_s[XLEN-1:0];
        else                      fix_res = prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) state_d = IDLE;
        else begin
            case (state_q)
                IDLE, DONE: state_d = accept ? (fast ? DONE : CALC) : IDLE;
                CALC:       state_d = (cnt_q == CW'(XLEN-1)) ? FIX : CALC;
                FIX:        state_d = DONE;
                default:    state_d = IDLE;
            endcase
        end
    end

    logic              busy_d, done_d, wen_d;
    logic [XLEN-1:0]   result_d;
    logic [REG_AW-1:0] waddr_d;

    always_comb begin
        busy_d   = (state_d == CALC) || (state_d == FIX);
        done_d   = 1'b0;
        wen_d    = 1'b0;
        result_d = result_o;
        waddr_d  = w_addr_o;
        if (state_d == DONE) begin
            done_d = 1'b1;
            if (state_q == FIX) begin
                result_d = fix_res;
                waddr_d  = addr_q;
                wen_d    = (addr_q != '0);
            end else begin
                result_d = fast_res;
                waddr_d  = w_addr_i;
                wen_d    = (w_addr_i != '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            w_enable_o <= 1'b0;
            result_o   <= '0;
            w_addr_o   <= '0;
        end else begin
            busy_o     <= busy_d;
            done_o     <= done_d;
            w_enable_o <= wen_d;
            result_o   <= result_d;
            w_addr_o   <= waddr_d;
        end
    end

    // MUL keeps the multiplier in lo and multiplicand in opb; DIV keeps dividend in lo, divisor in opb
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            addr_q  <= '0;
        end else if (accept) begin
            cnt_q   <= '0;
            op_q    <= op_i;
            hi_q    <= '0;
            lo_q    <= is_div ? a_mag : b_mag;
            opb_q   <= is_div ? b_mag : a_mag;
            neg_a_q <= a_neg;
            neg_b_q <= b_neg;
            addr_q  <= w_addr_i;
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q + 1'b1;
            hi_q  <= op_q[2] ? div_hi_n : mul_hi_n;
            lo_q  <= op_q[2] ? div_lo_n : mul_lo_n;
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv at XLEN=32 with hand-computed expectations.
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst, start_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] a_i, b_i;
    logic [4:0]  w_addr_i;
    logic        busy_o, done_o, w_enable_o;
    logic [31:0] result_o;
    logic [4:0]  w_addr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .w_addr_i(w_addr_i), .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o),
        .result_o(result_o), .w_enable_o(w_enable_o), .w_addr_o(w_addr_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request; pulse_at > 0 re-asserts start with junk operands mid-operation.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wa, input int lat,
                         input logic [31:0] exp, input logic exp_wen, input int pulse_at);
        int n;
        @(negedge clk);
        op_i = op; a_i = a; b_i = b; w_addr_i = wa; start_i = 1'b1;
        @(posedge clk); #1;
        n = 1;
        start_i = 1'b0;
        chk({tag, " busy"}, 64'(busy_o), 64'(lat > 1));
        while (!done_o && n < 200) begin
            if (n == pulse_at) begin
                start_i = 1'b1; op_i = 3'd5; a_i = 32'd99; b_i = 32'd1; w_addr_i = 5'd9;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start_i = 1'b0;
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " result"}, 64'(result_o), 64'(exp));
        chk({tag, " w_enable"}, 64'(w_enable_o), 64'(exp_wen));
        chk({tag, " w_addr"}, 64'(w_addr_o), 64'(wa));
        @(posedge clk); #1;
        chk({tag, " done pulse"}, 64'(done_o), 64'(0));
    endtask

    initial begin
        int seen;
        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0; a_i = '0; b_i = '0; w_addr_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy_o), 64'(0));
        chk("reset done", 64'(done_o), 64'(0));
        chk("reset result", 64'(result_o), 64'(0));
        chk("reset wen", 64'(w_enable_o), 64'(0));
        chk("reset waddr", 64'(w_addr_o), 64'(0));
        @(negedge clk); rst = 1'b0;

        do_op("mul",     3'd0, 32'd7,        32'hFFFFFFFD, 5'd3, 34, 32'hFFFFFFEB, 1'b1, 0);
        do_op("mulhu",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 34, 32'hFFFFFFFE, 1'b1, 0);
        do_op("mulh",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 34, 32'h00000000, 1'b1, 0);
        do_op("mulhsu",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 34, 32'hFFFFFFFF, 1'b1, 0);
        do_op("div",     3'd4, 32'hFFFFFFF9, 32'd2,        5'd6, 34, 32'hFFFFFFFD, 1'b1, 0);
        do_op("rem",     3'd6, 32'hFFFFFFF9, 32'd2,        5'd7, 34, 32'hFFFFFFFF, 1'b1, 0);
        do_op("divu",    3'd5, 32'd100,      32'd7,        5'd8, 34, 32'd14,       1'b1, 0);
        do_op("remu",    3'd7, 32'd100,      32'd7,        5'd8, 34, 32'd2,        1'b1, 0);
        do_op("div0",    3'd4, 32'd5,        32'd0,        5'd1, 1,  32'hFFFFFFFF, 1'b1, 0);
        do_op("remu0",   3'd7, 32'd123,      32'd0,        5'd1, 1,  32'd123,      1'b1, 0);
        do_op("rem ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd2, 1,  32'h00000000, 1'b1, 0);
        do_op("div ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd2, 1,  32'h80000000, 1'b1, 0);

        // Flush mid-CALC: no done, result unchanged
        @(negedge clk);
        op_i = 3'd5; a_i = 32'd1000; b_i = 32'd3; w_addr_i = 5'd10; start_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); flush_i = 1'b1;
        @(posedge clk); #1;
        chk("flush busy", 64'(busy_o), 64'(0));
        chk("flush done", 64'(done_o), 64'(0));
        chk("flush result hold", 64'(result_o), 64'(32'h80000000));
        @(negedge clk); flush_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_o) seen++;
        end
        chk("flush no done", 64'(seen), 64'(0));

        // Start re-pulsed while busy must be ignored
        do_op("mul after flush", 3'd0, 32'd3, 32'd4, 5'd11, 34, 32'd12, 1'b1, 8);

        // Flush together with start in IDLE: flush wins
        @(negedge clk);
        op_i = 3'd0; a_i = 32'd5; b_i = 32'd5; w_addr_i = 5'd12; start_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        chk("flush+start busy", 64'(busy_o), 64'(0));

        // Reset mid-CALC
        @(negedge clk);
        op_i = 3'd5; a_i = 32'd77; b_i = 32'd5; w_addr_i = 5'd13; start_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("rst busy", 64'(busy_o), 64'(0));
        chk("rst done", 64'(done_o), 64'(0));
        chk("rst result", 64'(result_o), 64'(0));
        chk("rst wen", 64'(w_enable_o), 64'(0));
        chk("rst waddr", 64'(w_addr_o), 64'(0));
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_o) seen++;
        end
        chk("rst no done", 64'(seen), 64'(0));

        do_op("waddr0", 3'd0, 32'd6, 32'd7, 5'd0, 34, 32'd42, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
